axi_uio_link_responder: RTL
===========================

# axi_uio_link_responder

Link-partner responder for one user-IO lane: sits on the far side of the AXI-stream TX/RX pair driven by the user-IO-to-AXI converter and stands in for the serial link. It accepts 64-bit TX beats, reassembles 128-bit user-IO frames, buffers them, and returns each frame unmodified as two 64-bit RX beats. It also models link bring-up and counts good and malformed frames. It is used in loopback benches and in link-less builds.

## Interface
- FIFO_DEPTH, 8, frame buffer depth in 128-bit frames; power of 2, ≥2
- LINK_UP_DLY, 16, cycles from reset release to o_stat_chan_up; ≥1
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- i_s_axi_tx_tkeep  in  8  TX byte enables
- i_s_axi_tx_tdata  in  64  TX data
- i_s_axi_tx_tlast  in  1  TX end of frame
- i_s_axi_tx_tvalid  in  1  TX beat valid
- o_s_axi_tx_tready  out  1  TX beat accept
- o_m_axi_rx_tkeep  out  8  RX byte enables
- o_m_axi_rx_tdata  out  64  RX data
- o_m_axi_rx_tlast  out  1  RX end of frame
- o_m_axi_rx_tvalid  out  1  RX beat valid; no ready, consumer must sink every beat
- o_stat_chan_up  out  1  modelled link up, sticky until reset
- i_rx_pause  in  1  withholds new RX frames; sampled only at frame boundaries
- o_frame_cnt  out  32  good frames accepted; wraps
- o_err_cnt  out  16  malformed frames dropped; saturates at 0xFFFF

## Operation
- Frame format: beat0 carries frame[63:0] with tlast=0; beat1 carries frame[127:64] with tlast=1. Both beats have tkeep=0xFF.
- Link-up counter: counts from reset release. o_stat_chan_up sets when the count reaches LINK_UP_DLY−1 and stays set.
- o_s_axi_tx_tready = o_stat_chan_up & (fifo_count < FIFO_DEPTH). The ready term is combinational from registered state.
- A beat is accepted when tvalid & tready.
- Ingest FSM states are LO and HI; reset state is LO.
  - LO, accepted beat with tlast=0 and tkeep=0xFF: capture tdata into lo_reg, go to HI.
  - LO, accepted beat with any other tlast/tkeep: increment err, drop the beat, stay in LO.
  - HI, accepted beat with tlast=1 and tkeep=0xFF: push {tdata, lo_reg}, increment frame_cnt, go to LO.
  - HI, accepted beat with any other tlast/tkeep: increment err, drop both beats, go to LO.
- The FIFO is never pushed while full, because tready already masks this. There is no overflow path.
- Emit FSM states are IDLE, B0 and B1; reset state is IDLE.
  - IDLE, FIFO non-empty and !i_rx_pause: pop, go to B0.
  - B0: drive the low half, tlast=0. Go to B1.
  - B1: drive the high half, tlast=1.
  - B1 exit: if the FIFO is non-empty and !i_rx_pause, pop and go to B0 (back-to-back frames). Otherwise go to IDLE.
- RX outputs are registered. tvalid=1 only in B0/B1. tkeep=0xFF when valid, else 0. tdata is held at its last value when idle.
- A push and a pop in the same cycle leave fifo_count unchanged.
- Reset values: every output is 0, including o_s_axi_tx_tready, all RX outputs, o_stat_chan_up and both counters.
- Reset asserted mid-frame discards lo_reg, all FIFO contents and any in-flight RX frame. After release, no truncated frame is ever emitted.

## Timing
- Beat1 accepted at edge N: FIFO count is non-empty from N. With the emitter IDLE, RX beat0 is valid in the cycle after edge N+1 and beat1 in the cycle after edge N+2. Ingress-to-egress latency is 2 cycles.
- Sustained throughput is 1 beat/clk in each direction. Each RX frame occupies exactly 2 consecutive cycles.
- If i_rx_pause rises during B0, the current frame still completes through B1.
- The tready drop on full takes effect in the cycle after the push that fills the FIFO.

## Structure
- Shared package uio_link_pkg holds:
  - BEAT_W=64, KEEP_W=8, FRAME_W=128, KEEP_ALL=8'hFF
  - ingest state enum {LO, HI} and emit state enum {IDLE, B0, B1}
- Sub-module uio_link_fifo: synchronous FIFO, width FRAME_W, depth FIFO_DEPTH. Outputs are count, empty and full. Read data is valid the cycle after the pop (registered output); the emit FSM latches it entering B0.

## Test plan
- Bring-up: release reset with tvalid=1 held → tready=0 and chan_up=0 for 15 cycles; both rise at cycle 16 (LINK_UP_DLY=16).
- Loopback: send 0x1111…_2222… as two legal beats → RX beat0=0x…2222, tlast=0; beat1=0x…1111, tlast=1. RX beat0 appears 2 cycles after TX beat1. frame_cnt=1.
- Framing errors: send tlast=1 on beat0, then tkeep=0x0F on beat1 of the next frame, then a good frame → err_cnt=2, frame_cnt=1, only the good frame emitted.
- Back-pressure: i_rx_pause=1, stream 10 frames → tready low after 8 frames accepted. Release pause → 16 contiguous RX beats without bubbles, then the remaining 2 frames; total 10 frames in order.
- Pause mid-frame: raise i_rx_pause during B0 → B1 still emitted, no further tvalid until release.
- Reset mid-operation: assert reset_n=0 while the FIFO holds 3 frames and RX is in B0 → all outputs 0 immediately. After release: no RX beats, counters 0.

Source files
------------

// File: rtl/uio_link_pkg.sv
// Shared widths, constants and FSM state types for the user-IO link responder.
package uio_link_pkg;

    localparam int BEAT_W  = 64;
    localparam int KEEP_W  = 8;
    localparam int FRAME_W = 128;
    localparam logic [KEEP_W-1:0] KEEP_ALL = 8'hFF;

    // Ingest: LO waits for the low beat, HI waits for the closing high beat.
    typedef enum logic {
        LO,
        HI
    } ingest_state_t;

    // Emit: IDLE, then the low beat (B0) and the high beat (B1) of a frame.
    typedef enum logic [1:0] {
        IDLE,
        B0,
        B1
    } emit_state_t;

endpackage

// File: rtl/axi_uio_link_responder_if.sv
// AXI-stream TX/RX pair between the user-IO converter (master) and the
// link responder (slave).
interface axi_uio_link_responder_if;
    import uio_link_pkg::*;

    logic [KEEP_W-1:0] i_s_axi_tx_tkeep;
    logic [BEAT_W-1:0] i_s_axi_tx_tdata;
    logic              i_s_axi_tx_tlast;
    logic              i_s_axi_tx_tvalid;
    logic              o_s_axi_tx_tready;
    logic [KEEP_W-1:0] o_m_axi_rx_tkeep;
    logic [BEAT_W-1:0] o_m_axi_rx_tdata;
    logic              o_m_axi_rx_tlast;
    logic              o_m_axi_rx_tvalid;

    modport master (
        output i_s_axi_tx_tkeep, i_s_axi_tx_tdata, i_s_axi_tx_tlast, i_s_axi_tx_tvalid,
        input  o_s_axi_tx_tready,
        input  o_m_axi_rx_tkeep, o_m_axi_rx_tdata, o_m_axi_rx_tlast, o_m_axi_rx_tvalid
    );

    modport slave (
        input  i_s_axi_tx_tkeep, i_s_axi_tx_tdata, i_s_axi_tx_tlast, i_s_axi_tx_tvalid,
        output o_s_axi_tx_tready,
        output o_m_axi_rx_tkeep, o_m_axi_rx_tdata, o_m_axi_rx_tlast, o_m_axi_rx_tvalid
    );

endinterface

// File: rtl/uio_link_fifo.sv
// Synchronous frame FIFO. Storage is a plain array with a registered read
// port so it maps onto block RAM; pop_data is valid the cycle after pop.
module uio_link_fifo #(
    parameter  int WIDTH = 128,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    // RAM write and registered read; left unreset so it stays a RAM primitive.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
        if (pop) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    // Pointers wrap naturally (power-of-two depth); push+pop keeps count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign pop_data = rd_data_reg;
    assign count    = count_reg;
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/axi_uio_link_responder.sv
// Link-partner responder: reassembles 2-beat TX frames, buffers them and
// loops each one back unmodified as 2 RX beats; models link bring-up and
// counts good and malformed frames.
module axi_uio_link_responder
    import uio_link_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int LINK_UP_DLY = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    axi_uio_link_responder_if.slave axis,
    input  logic                    i_rx_pause,
    output logic                    o_stat_chan_up,
    output logic [31:0]             o_frame_cnt,
    output logic [15:0]             o_err_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = $clog2(LINK_UP_DLY) + 1;

    logic [LW-1:0]      link_cnt_reg;
    logic               chan_up_reg;
    ingest_state_t      ing_state_reg;
    logic [BEAT_W-1:0]  lo_reg;
    logic [31:0]        frame_cnt_reg;
    logic [15:0]        err_cnt_reg;
    emit_state_t        emit_state_reg;
    logic               rx_valid_reg;
    logic               rx_last_reg;
    logic [KEEP_W-1:0]  rx_keep_reg;
    logic [BEAT_W-1:0]  rx_hold_reg;

    logic               tx_ready;
    logic               tx_accept;
    logic               beat_full;
    logic               frame_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CW-1:0]      fifo_count;
    logic [FRAME_W-1:0] fifo_rd_data;

    assign tx_ready   = chan_up_reg && (fifo_count < CW'(FIFO_DEPTH));
    assign tx_accept  = axis.i_s_axi_tx_tvalid && tx_ready;
    assign beat_full  = (axis.i_s_axi_tx_tkeep == KEEP_ALL);
    assign frame_push = tx_accept && (ing_state_reg == HI)
                        && axis.i_s_axi_tx_tlast && beat_full;
    // Frames start only from IDLE or at the end of B1, so pause acts on
    // frame boundaries and an emitted frame is never split.
    assign fifo_pop   = (emit_state_reg != B0) && !fifo_empty && !i_rx_pause;

    uio_link_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (frame_push && !fifo_full),
        .push_data ({axis.i_s_axi_tx_tdata, lo_reg}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Link bring-up: count from reset release, then latch link-up for good.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            link_cnt_reg <= '0;
            chan_up_reg  <= 1'b0;
        end else if (!chan_up_reg) begin
            if (link_cnt_reg == LW'(LINK_UP_DLY - 1)) begin
                chan_up_reg <= 1'b1;
            end else begin
                link_cnt_reg <= link_cnt_reg + 1'b1;
            end
        end
    end

    // Ingest FSM: pair a clean low beat with a clean closing beat, else drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ing_state_reg <= LO;
            lo_reg        <= '0;
            frame_cnt_reg <= '0;
            err_cnt_reg   <= '0;
        end else if (tx_accept) begin
            if (ing_state_reg == LO) begin
                if (!axis.i_s_axi_tx_tlast && beat_full) begin
                    lo_reg        <= axis.i_s_axi_tx_tdata;
                    ing_state_reg <= HI;
                end else if (err_cnt_reg != 16'hFFFF) begin
                    err_cnt_reg <= err_cnt_reg + 1'b1;
                end
            end else begin
                ing_state_reg <= LO;
                if (axis.i_s_axi_tx_tlast && beat_full) begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end else if (err_cnt_reg != 16'hFFFF) begin
                    err_cnt_reg <= err_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Emit FSM: the pop lands the frame in the FIFO read register entering
    // B0; the high half is copied to the hold register entering B1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            emit_state_reg <= IDLE;
            rx_valid_reg   <= 1'b0;
            rx_last_reg    <= 1'b0;
            rx_keep_reg    <= '0;
            rx_hold_reg    <= '0;
        end else begin
            case (emit_state_reg)
                IDLE: begin
                    if (fifo_pop) begin
                        emit_state_reg <= B0;
                        rx_valid_reg   <= 1'b1;
                        rx_last_reg    <= 1'b0;
                        rx_keep_reg    <= KEEP_ALL;
                    end
                end
                B0: begin
                    emit_state_reg <= B1;
                    rx_last_reg    <= 1'b1;
                    rx_hold_reg    <= fifo_rd_data[FRAME_W-1:BEAT_W];
                end
                B1: begin
                    if (fifo_pop) begin
                        emit_state_reg <= B0;
                        rx_last_reg    <= 1'b0;
                    end else begin
                        emit_state_reg <= IDLE;
                        rx_valid_reg   <= 1'b0;
                        rx_last_reg    <= 1'b0;
                        rx_keep_reg    <= '0;
                    end
                end
                default: begin
                    emit_state_reg <= IDLE;
                    rx_valid_reg   <= 1'b0;
                    rx_last_reg    <= 1'b0;
                    rx_keep_reg    <= '0;
                end
            endcase
        end
    end

    // In B0 the low half comes straight from the FIFO read register; at all
    // other times the hold register supplies the last high half (0 after reset).
    assign axis.o_m_axi_rx_tdata  = (emit_state_reg == B0) ? fifo_rd_data[BEAT_W-1:0]
                                                           : rx_hold_reg;
    assign axis.o_m_axi_rx_tvalid = rx_valid_reg;
    assign axis.o_m_axi_rx_tlast  = rx_last_reg;
    assign axis.o_m_axi_rx_tkeep  = rx_keep_reg;
    assign axis.o_s_axi_tx_tready = tx_ready;

    assign o_stat_chan_up = chan_up_reg;
    assign o_frame_cnt    = frame_cnt_reg;
    assign o_err_cnt      = err_cnt_reg;

endmodule
